// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one external 16-bit asynchronous SRAM (20-bit word address) between a
// write requester (recorder capture) and a read requester (playback). Generates
// CE_N/WE_N/OE_N/LB_N/UB_N timing from the system clock and owns the DQ
// tri-state.
//
// Optional build macro: SRAM_ARB_RR_EN
//   undefined : fixed priority, write wins when both ports request in IDLE
//   defined   : round-robin between the ports using a 1-bit last_grant register
//
// Ports:
//   i_clk, i_rst             clock (50 MHz) and synchronous active-high reset
//   i_wr_req/addr/data       write request (level, held until o_wr_ack)
//   o_wr_ack                 one-cycle pulse, write accepted and latched
//   i_rd_req/addr            read request (level, held until o_rd_ack)
//   o_rd_ack                 one-cycle pulse, read accepted and latched
//   o_rd_data, o_rd_valid    read data (held) and its one-cycle update pulse
//   o_busy, o_state          FSM not idle / state code for debug display
//   SRAM_*                   SRAM pins, strobes active-low
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int WR_PULSE_CYCLES = 1,
   parameter int RD_WAIT_CYCLES  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr_req,
   input  logic [19:0] i_wr_addr,
   input  logic [15:0] i_wr_data,
   output logic        o_wr_ack,
   input  logic        i_rd_req,
   input  logic [19:0] i_rd_addr,
   output logic        o_rd_ack,
   output logic [15:0] o_rd_data,
   output logic        o_rd_valid,
   output logic        o_busy,
   output logic [2:0]  o_state,
   inout  wire  [15:0] SRAM_DQ,
   output logic [19:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_UB_N
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_SETUP  = 3'd1,
      W_STROBE = 3'd2,
      W_HOLD   = 3'd3,
      R_WAIT   = 3'd4,
      R_DONE   = 3'd5
   } state_t;

   // Terminal counts for the multi-cycle states (counter runs 0..N-1)
   localparam logic [7:0] WR_LAST = 8'(WR_PULSE_CYCLES - 1);
   localparam logic [7:0] RD_LAST = 8'(RD_WAIT_CYCLES - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [15:0] dq_out;
   logic        dq_oe;
   logic        grant_wr;

   // DQ is only driven by the write states; released everywhere else
   assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;
   assign o_state = state;

`ifdef SRAM_ARB_RR_EN
   localparam logic LG_WRITE = 1'b0;
   localparam logic LG_READ  = 1'b1;

   logic last_grant;

   // Arbitration: on contention give the port that did not win last time
   always_comb begin
      grant_wr = 1'b0;
      if (i_wr_req && i_rd_req) begin
         grant_wr = (last_grant == LG_READ);
      end else begin
         grant_wr = i_wr_req;
      end
   end

   // Track which port received the most recent grant
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_grant <= LG_READ;
      end else if (state == IDLE && grant_wr) begin
         last_grant <= LG_WRITE;
      end else if (state == IDLE && i_rd_req) begin
         last_grant <= LG_READ;
      end else begin
         last_grant <= last_grant;
      end
   end
`else
   // Arbitration: fixed priority, a pending write always wins
   always_comb begin
      grant_wr = i_wr_req;
   end
`endif

   // Main sequencer: every pin and handshake output is set here so all are registered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         o_wr_ack   <= 1'b0;
         o_rd_ack   <= 1'b0;
         o_rd_valid <= 1'b0;
         o_rd_data  <= 16'h0000;
         o_busy     <= 1'b0;
         SRAM_ADDR  <= 20'h00000;
         SRAM_WE_N  <= 1'b1;
         SRAM_OE_N  <= 1'b1;
         SRAM_CE_N  <= 1'b1;
         SRAM_LB_N  <= 1'b1;
         SRAM_UB_N  <= 1'b1;
         dq_oe      <= 1'b0;
         dq_out     <= 16'h0000;
      end else begin
         // Handshake pulses last exactly one cycle
         o_wr_ack   <= 1'b0;
         o_rd_ack   <= 1'b0;
         o_rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= 8'd0;
               if (grant_wr) begin
                  state     <= W_SETUP;
                  o_wr_ack  <= 1'b1;
                  o_busy    <= 1'b1;
                  SRAM_ADDR <= i_wr_addr;
                  dq_out    <= i_wr_data;
                  dq_oe     <= 1'b1;
                  SRAM_CE_N <= 1'b0;
                  SRAM_LB_N <= 1'b0;
                  SRAM_UB_N <= 1'b0;
                  SRAM_WE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
               end else if (i_rd_req) begin
                  state     <= R_WAIT;
                  o_rd_ack  <= 1'b1;
                  o_busy    <= 1'b1;
                  SRAM_ADDR <= i_rd_addr;
                  dq_oe     <= 1'b0;
                  SRAM_CE_N <= 1'b0;
                  SRAM_OE_N <= 1'b0;
                  SRAM_LB_N <= 1'b0;
                  SRAM_UB_N <= 1'b0;
                  SRAM_WE_N <= 1'b1;
               end else begin
                  o_busy <= 1'b0;
               end
            end
            W_SETUP: begin
               state     <= W_STROBE;
               cnt       <= 8'd0;
               SRAM_WE_N <= 1'b0;
            end
            W_STROBE: begin
               if (cnt == WR_LAST) begin
                  state     <= W_HOLD;
                  SRAM_WE_N <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            W_HOLD: begin
               // Data stays on DQ through this cycle so it is held past WE_N rising
               state     <= IDLE;
               o_busy    <= 1'b0;
               dq_oe     <= 1'b0;
               SRAM_CE_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
            end
            R_WAIT: begin
               if (cnt == RD_LAST) begin
                  state      <= R_DONE;
                  o_rd_data  <= SRAM_DQ;
                  o_rd_valid <= 1'b1;
                  SRAM_OE_N  <= 1'b1;
                  SRAM_CE_N  <= 1'b1;
                  SRAM_LB_N  <= 1'b1;
                  SRAM_UB_N  <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            R_DONE: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               // Unreachable encodings fall back to idle pin values
               state     <= IDLE;
               cnt       <= 8'd0;
               o_busy    <= 1'b0;
               dq_oe     <= 1'b0;
               SRAM_WE_N <= 1'b1;
               SRAM_OE_N <= 1'b1;
               SRAM_CE_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter: SRAM behavioural model, scoreboard
// queues for grants, write strobes and read data, and directed tests.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int WR_PULSE = 1;
   localparam int RD_WAIT  = 2;
   localparam logic [7:0] G_W = 8'h57;
   localparam logic [7:0] G_R = 8'h52;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_req = 1'b0;
   logic [19:0] wr_addr = 20'h00000;
   logic [15:0] wr_data = 16'h0000;
   logic        wr_ack;
   logic        rd_req = 1'b0;
   logic [19:0] rd_addr = 20'h00000;
   logic        rd_ack;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic [2:0]  state;
   wire  [15:0] sram_dq;
   logic [19:0] sram_addr;
   logic        we_n, oe_n, ce_n, lb_n, ub_n;

   // bench state
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          wr_ack_cnt = 0;
   logic        probe_en  = 1'b0;
   logic [15:0] probe_val = 16'h0000;
   logic [15:0] sram_mem [256];
   logic [15:0] ref_mem [logic [19:0]];
   logic [35:0] exp_wr [$];
   logic [15:0] exp_rd [$];
   logic [7:0]  exp_grant [$];
   logic [15:0] exp_rd_last = 16'h0000;

   // SRAM model drives DQ while selected for read; the probe checks DQ release
   assign sram_dq = probe_en ? probe_val :
                    (!ce_n && !oe_n) ? sram_mem[sram_addr[7:0]] : 16'hzzzz;

   sram_arbiter dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr_req   (wr_req),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_wr_ack   (wr_ack),
      .i_rd_req   (rd_req),
      .i_rd_addr  (rd_addr),
      .o_rd_ack   (rd_ack),
      .o_rd_data  (rd_data),
      .o_rd_valid (rd_valid),
      .o_busy     (busy),
      .o_state    (state),
      .SRAM_DQ    (sram_dq),
      .SRAM_ADDR  (sram_addr),
      .SRAM_WE_N  (we_n),
      .SRAM_OE_N  (oe_n),
      .SRAM_CE_N  (ce_n),
      .SRAM_LB_N  (lb_n),
      .SRAM_UB_N  (ub_n)
   );

   always #10 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Continuous monitor: strobes, bus contention, grants, read data
   initial begin
      int we_cnt = 0;
      int oe_cnt = 0;
      logic [35:0] w;
      logic [15:0] r;
      logic [7:0]  g;
      for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;
      forever begin
         @(negedge clk);
         if (!ce_n && !we_n) begin
            chk("we_oe_exclusive", 32'(oe_n), 32'd1);
            if (we_cnt == 0) begin
               if (exp_wr.size() == 0) begin
                  chk("wr_unexpected", 32'd1, 32'd0);
               end else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", 32'(sram_addr), 32'(w[35:16]));
                  chk("wr_data", 32'(sram_dq), 32'(w[15:0]));
                  chk("wr_lanes", 32'({lb_n, ub_n}), 32'd0);
               end
               sram_mem[sram_addr[7:0]] = sram_dq;
            end
            we_cnt = we_cnt + 1;
         end else if (we_cnt != 0) begin
            chk("we_pulse_len", 32'(we_cnt), 32'(WR_PULSE));
            we_cnt = 0;
         end
         if (!oe_n) begin
            // any DUT drive on DQ here would corrupt the model's value
            chk("dq_contention", 32'(sram_dq), 32'(sram_mem[sram_addr[7:0]]));
            oe_cnt = oe_cnt + 1;
         end else if (oe_cnt != 0) begin
            chk("oe_low_len", 32'(oe_cnt), 32'(RD_WAIT));
            oe_cnt = 0;
         end
         if (wr_ack || rd_ack) begin
            chk("ack_exclusive", 32'(wr_ack & rd_ack), 32'd0);
            if (wr_ack) wr_ack_cnt = wr_ack_cnt + 1;
            if (exp_grant.size() == 0) begin
               chk("grant_unexpected", 32'd1, 32'd0);
            end else begin
               g = exp_grant.pop_front();
               chk("grant_order", wr_ack ? 32'(G_W) : 32'(G_R), 32'(g));
            end
         end
         if (rd_valid) begin
            if (exp_rd.size() == 0) begin
               chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
               r = exp_rd.pop_front();
               chk("rd_data", 32'(rd_data), 32'(r));
               exp_rd_last = r;
            end
         end else if (!rst) begin
            chk("rd_data_hold", 32'(rd_data), 32'(exp_rd_last));
         end
      end
   end

   task automatic push_wr(input logic [19:0] a, input logic [15:0] d);
      exp_wr.push_back({a, d});
      ref_mem[a] = d;
   endtask

   task automatic do_writes(input int n, input logic [19:0] base, input logic [15:0] dbase, input int gap);
      int last = 0;
      logic got;
      for (int i = 0; i < n; i++) begin
         wr_addr = base + 20'(i);
         wr_data = dbase + 16'(i);
         push_wr(wr_addr, wr_data);
         wr_req = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (wr_ack) got = 1'b1;
         end
         chk("wr_ack_seen", 32'(got), 32'd1);
         if (got && i > 0) chk("wr_ack_gap", 32'(cyc - last), 32'(gap));
         last = cyc;
      end
      wr_req = 1'b0;
   endtask

   task automatic do_reads(input int n, input logic [19:0] base, input int gap);
      int last = 0;
      logic got;
      for (int i = 0; i < n; i++) begin
         rd_addr = base + 20'(i);
         exp_rd.push_back(ref_mem[rd_addr]);
         rd_req = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (rd_ack) got = 1'b1;
         end
         chk("rd_ack_seen", 32'(got), 32'd1);
         if (got && i > 0) chk("rd_ack_gap", 32'(cyc - last), 32'(gap));
         last = cyc;
      end
      rd_req = 1'b0;
   endtask

   task automatic probe_release(input string tag, input logic [15:0] v);
      probe_val = v;
      probe_en  = 1'b1;
      #1;
      chk(tag, 32'(sram_dq), 32'(v));
      probe_en  = 1'b0;
   endtask

   initial begin
      int gap_w;
      int gap_r;
      int acks_before;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", 32'({we_n, oe_n, ce_n, lb_n, ub_n}), 32'h1F);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_acks", 32'({wr_ack, rd_ack, rd_valid}), 32'd0);
      probe_release("rst_dq_z", 16'h1234);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ---- single write ----
      exp_grant.push_back(G_W);
      push_wr(20'h00123, 16'hBEEF);
      wr_addr = 20'h00123;
      wr_data = 16'hBEEF;
      wr_req  = 1'b1;
      @(negedge clk);
      chk("sw_ack", 32'(wr_ack), 32'd1);
      chk("sw_setup_state", 32'(state), 32'd1);
      chk("sw_setup_pins", 32'({we_n, ce_n, lb_n, ub_n}), 32'h8);
      chk("sw_busy", 32'(busy), 32'd1);
      wr_req = 1'b0;
      @(negedge clk);
      chk("sw_strobe_state", 32'(state), 32'd2);
      chk("sw_we_low", 32'(we_n), 32'd0);
      @(negedge clk);
      chk("sw_hold_state", 32'(state), 32'd3);
      chk("sw_hold_dq", 32'(sram_dq), 32'hBEEF);
      chk("sw_hold_we", 32'(we_n), 32'd1);
      @(negedge clk);
      chk("sw_idle_state", 32'(state), 32'd0);
      chk("sw_idle_ce", 32'(ce_n), 32'd1);
      probe_release("sw_dq_z", 16'h1234);
      repeat (2) @(negedge clk);

      // ---- read-back ----
      exp_grant.push_back(G_R);
      exp_rd.push_back(16'hBEEF);
      rd_addr = 20'h00123;
      rd_req  = 1'b1;
      @(negedge clk);
      chk("rb_ack", 32'(rd_ack), 32'd1);
      chk("rb_wait_state", 32'(state), 32'd4);
      chk("rb_oe_ce", 32'({oe_n, ce_n}), 32'd0);
      rd_req = 1'b0;
      @(negedge clk);
      chk("rb_wait2_state", 32'(state), 32'd4);
      @(negedge clk);
      chk("rb_done_state", 32'(state), 32'd5);
      chk("rb_valid", 32'(rd_valid), 32'd1);
      chk("rb_done_pins", 32'({oe_n, ce_n}), 32'h3);
      @(negedge clk);
      chk("rb_idle_state", 32'(state), 32'd0);
      chk("rb_idle_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);

      // ---- back-to-back writes then reads ----
      repeat (3) exp_grant.push_back(G_W);
      do_writes(3, 20'h00000, 16'h0001, 4);
      repeat (4) @(negedge clk);
      repeat (3) exp_grant.push_back(G_R);
      do_reads(3, 20'h00000, 4);
      repeat (6) @(negedge clk);

      // ---- simultaneous requests ----
`ifdef SRAM_ARB_RR_EN
      for (int i = 0; i < 3; i++) begin
         exp_grant.push_back(G_W);
         exp_grant.push_back(G_R);
      end
      gap_w = 8;
      gap_r = 8;
`else
      repeat (3) exp_grant.push_back(G_W);
      repeat (3) exp_grant.push_back(G_R);
      gap_w = 4;
      gap_r = 4;
`endif
      fork
         do_writes(3, 20'h00040, 16'hA0A1, gap_w);
         do_reads(3, 20'h00000, gap_r);
      join
      repeat (6) @(negedge clk);
      repeat (3) exp_grant.push_back(G_R);
      do_reads(3, 20'h00040, 4);
      repeat (6) @(negedge clk);

      // ---- reset during write strobe ----
      exp_grant.push_back(G_W);
      push_wr(20'h000F0, 16'h5555);
      wr_addr = 20'h000F0;
      wr_data = 16'h5555;
      wr_req  = 1'b1;
      @(negedge clk);
      chk("rw_ack", 32'(wr_ack), 32'd1);
      wr_req = 1'b0;
      @(negedge clk);
      chk("rw_strobe", 32'({state, we_n}), 32'({3'd2, 1'b0}));
      rst = 1'b1;
      exp_rd_last = 16'h0000;
      acks_before = wr_ack_cnt;
      @(negedge clk);
      chk("rw_state", 32'(state), 32'd0);
      chk("rw_busy", 32'(busy), 32'd0);
      chk("rw_pins", 32'({we_n, oe_n, ce_n, lb_n, ub_n}), 32'h1F);
      chk("rw_rd_data", 32'(rd_data), 32'd0);
      probe_release("rw_dq_z", 16'h1234);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("rw_no_ack", 32'(wr_ack_cnt), 32'(acks_before));

      // ---- recovery read after reset ----
      exp_grant.push_back(G_R);
      do_reads(1, 20'h00123, 4);
      repeat (8) @(negedge clk);

      chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
      chk("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
      chk("sb_grant_empty", 32'(exp_grant.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
